ppi_kbd_port: RTL

- Mode-0-only KR580VV55 (i8255-compatible) parallel port block; CPU-facing register file driving the keyboard matrix scan.
- Sits directly downstream of the CPU bus and upstream of the keyboard matrix stage:
  - port A plus the lower nibble of port C feed the 12-bit column scan.
  - port B returns the 6 row lines plus the NR (shift) line.
- Also carries the other Specialist port-C/port-B side signals (tape, sound) through to the system glue logic.

---
 rtl/ppi_kbd_port.sv | 107 ++++++++++
 1 files changed

// File: rtl/ppi_kbd_port.sv
// rtl/ppi_kbd_port.sv - mode-0 i8255-compatible parallel port driving the keyboard matrix scan
module ppi_kbd_port #(
    parameter logic [7:0] RESET_CW = 8'h9B,
    parameter logic [7:0] IDLE_OUT = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       wr,
    input  logic       rd,
    input  logic [1:0] addr,
    input  logic [7:0] idata,
    output logic [7:0] odata,
    input  logic [7:0] pa_i,
    output logic [7:0] pa_o,
    input  logic [7:0] pb_i,
    output logic [7:0] pb_o,
    input  logic [7:0] pc_i,
    output logic [7:0] pc_o,
    output logic [3:0] dir
);

    logic [7:0] cw;
    logic [7:0] la;
    logic [7:0] lb;
    logic [7:0] lc;
    logic       armed;
    logic       dir_a;
    logic       dir_cu;
    logic       dir_b;
    logic       dir_cl;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] rd_mux;
    logic       unused_mode_bits;

    assign dir_a  = cw[4];
    assign dir_cu = cw[3];
    assign dir_b  = cw[1];
    assign dir_cl = cw[0];
    assign dir    = {dir_a, dir_cu, dir_b, dir_cl};

    // Mode bits are kept in cw so the register holds what the CPU wrote; only mode 0 exists here.
    assign unused_mode_bits = ^{cw[7:5], cw[2]};

    // armed stays low for the first edge after reset release so a strobe there is dropped.
    assign wr_en = cs & wr & armed;
    assign rd_en = cs & rd & armed;

    assign pa_o = dir_a ? IDLE_OUT : la;
    assign pb_o = dir_b ? IDLE_OUT : lb;
    assign pc_o = {dir_cu ? IDLE_OUT[7:4] : lc[7:4],
                   dir_cl ? IDLE_OUT[3:0] : lc[3:0]};

    always_comb begin
        rd_mux = 8'hFF;
        case (addr)
            2'd0:    rd_mux = dir_a ? pa_i : la;
            2'd1:    rd_mux = dir_b ? pb_i : lb;
            2'd2:    rd_mux = {dir_cu ? pc_i[7:4] : lc[7:4],
                               dir_cl ? pc_i[3:0] : lc[3:0]};
            default: rd_mux = 8'hFF;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            odata <= 8'hFF;
        end else if (rd_en) begin
            odata <= rd_mux;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cw <= RESET_CW;
            la <= 8'h00;
            lb <= 8'h00;
            lc <= 8'h00;
        end else if (wr_en) begin
            case (addr)
                2'd0: la <= idata;
                2'd1: lb <= idata;
                2'd2: lc <= idata;
                default: begin
                    if (idata[7]) begin
                        cw <= idata;
                        la <= 8'h00;
                        lb <= 8'h00;
                        lc <= 8'h00;
                    end else begin
                        lc[idata[3:1]] <= idata[0];
                    end
                end
            endcase
        end
    end

endmodule
